// File: rtl/dac_spi_tx.sv
// Drives an MCP4901-style 8-bit DAC: one 16-bit SPI write frame per sample, then an LDAC strobe.
// A one-entry buffer holds a sample that arrives mid-frame; overwrites are counted (saturating).
module dac_spi_tx #(
  parameter int         SCLK_DIV = 4,
  parameter logic [3:0] CFG_BITS = 4'b0011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic       busy,
  output logic       pending,
  output logic [7:0] overrun_cnt,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_ldac_n
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic [4:0]  half_reg;
  logic [15:0] shreg_reg;
  logic [7:0]  buf_reg;
  logic        buf_valid_reg;
  logic [7:0]  overrun_reg;
  logic        busy_reg, pending_reg, cs_n_reg, sclk_reg, mosi_reg, ldac_n_reg;
  logic        busy_next, pending_next, cs_n_next, sclk_next, mosi_next, ldac_n_next;
  logic        tick, idle, start, shift_out;

  assign tick      = (cnt_reg == 8'(SCLK_DIV - 1));
  assign idle      = (state_reg == IDLE);
  assign start     = idle && (buf_valid_reg || sample_valid);
  // Even half-periods are SCLK high; the next bit is presented as SCLK falls.
  assign shift_out = (state_reg == SHIFT) && tick && !half_reg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (start) state_next = SETUP;
      SETUP: if (tick) state_next = SHIFT;
      SHIFT: if (tick && half_reg == 5'd31) state_next = HOLD;
      HOLD:  if (tick) state_next = LDAC;
      LDAC:  if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      half_reg      <= '0;
      shreg_reg     <= '0;
      buf_reg       <= '0;
      buf_valid_reg <= 1'b0;
      overrun_reg   <= '0;
    end else begin
      cnt_reg <= (idle || tick) ? 8'd0 : cnt_reg + 8'd1;

      if (state_reg == SETUP)               half_reg <= '0;
      else if (state_reg == SHIFT && tick)  half_reg <= half_reg + 5'd1;

      if (start)
        shreg_reg <= {CFG_BITS, (buf_valid_reg ? buf_reg : sample), 4'b0000};
      else if (shift_out)
        shreg_reg <= {shreg_reg[14:0], 1'b0};

      // In IDLE a full buffer is consumed and refilled by a same-cycle strobe without an overrun.
      if (idle) begin
        if (buf_valid_reg) begin
          buf_valid_reg <= sample_valid;
          if (sample_valid) buf_reg <= sample;
        end
      end else if (sample_valid) begin
        buf_reg       <= sample;
        buf_valid_reg <= 1'b1;
        if (buf_valid_reg && overrun_reg != 8'hFF) overrun_reg <= overrun_reg + 8'd1;
      end
    end
  end

  always_comb begin
    busy_next    = !idle;
    pending_next = buf_valid_reg;
    cs_n_next    = !(state_reg == SETUP || state_reg == SHIFT);
    sclk_next    = (state_reg == SHIFT) && !half_reg[0];
    mosi_next    = (state_reg == SETUP || state_reg == SHIFT) ? shreg_reg[15] : 1'b0;
    ldac_n_next  = (state_reg != LDAC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg    <= 1'b0;
      pending_reg <= 1'b0;
      cs_n_reg    <= 1'b1;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      ldac_n_reg  <= 1'b1;
    end else begin
      busy_reg    <= busy_next;
      pending_reg <= pending_next;
      cs_n_reg    <= cs_n_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      ldac_n_reg  <= ldac_n_next;
    end
  end

  assign busy        = busy_reg;
  assign pending     = pending_reg;
  assign overrun_cnt = overrun_reg;
  assign spi_cs_n    = cs_n_reg;
  assign spi_sclk    = sclk_reg;
  assign spi_mosi    = mosi_reg;
  assign spi_ldac_n  = ldac_n_reg;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Randomized bench for dac_spi_tx: a timeline model of frames/buffer predicts outputs per cycle,
// and a bus monitor decodes SPI frames. A second instance covers the SCLK_DIV=1 corner.
module tb_dac_spi_tx;
  localparam int H         = 2;
  localparam int FRAME_CYC = 35 * H + 1;  // start-to-start spacing when back-to-back
  localparam int FAST_CYC  = 35 * 1 + 1;

  logic clk = 1'b0, rst_n = 1'b0, rst1_n = 1'b0;
  logic [7:0] sample = '0;
  logic sample_valid = 1'b0;
  logic busy, pending, cs_n, sclk, mosi, ldac_n;
  logic [7:0] overrun_cnt;
  logic [7:0] sample1 = 8'h55;
  logic sample_valid1 = 1'b0;
  logic busy1, pending1, cs1_n, sclk1, mosi1, ldac1_n;
  logic [7:0] overrun1;

  always #5 clk = ~clk;

  dac_spi_tx #(.SCLK_DIV(H), .CFG_BITS(4'b0011)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
    .busy(busy), .pending(pending), .overrun_cnt(overrun_cnt),
    .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_ldac_n(ldac_n));

  dac_spi_tx #(.SCLK_DIV(1), .CFG_BITS(4'b0011)) dut_fast (
    .clk(clk), .rst_n(rst1_n), .sample(sample1), .sample_valid(sample_valid1),
    .busy(busy1), .pending(pending1), .overrun_cnt(overrun1),
    .spi_cs_n(cs1_n), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_ldac_n(ldac1_n));

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [7:0] d);
    return {4'b0011, d, 4'b0000};
  endfunction

  // Reference model: edge index, frame start edge, first edge the driver is free again.
  int          m_t = 0, m_start = -1000, m_free = 0, m_over = 0;
  bit          m_pend = 0;
  logic [7:0]  m_buf = '0;
  logic [15:0] exp_q[$];

  task automatic step(input bit sv, input logic [7:0] s);
    bit exp_pend;
    sample = s;
    sample_valid = sv;
    @(posedge clk);
    m_t++;
    exp_pend = m_pend;
    if (m_t >= m_free) begin
      if (m_pend) begin
        exp_q.push_back(frame_of(m_buf));
        m_start = m_t; m_free = m_t + FRAME_CYC;
        if (sv) m_buf = s; else m_pend = 0;
      end else if (sv) begin
        exp_q.push_back(frame_of(s));
        m_start = m_t; m_free = m_t + FRAME_CYC;
      end
    end else if (sv) begin
      if (m_pend && m_over < 255) m_over++;
      m_pend = 1; m_buf = s;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    check("busy", busy, (m_t > m_start) && (m_t < m_free));
    check("cs_n", cs_n, !((m_t > m_start) && (m_t <= m_start + 33 * H)));
    check("ldac_n", ldac_n, !((m_t > m_start + 34 * H) && (m_t < m_free)));
    check("pending", pending, exp_pend);
    check("overrun", overrun_cnt, m_over);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_t < m_free + 4 || m_pend) && n < 2000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("drain_timeout", n < 2000, 1);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Monitor for the main instance: decodes frames and checks SPI/LDAC timing.
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        prev_cs = 1, prev_sclk = 0, prev_ldac = 1, prev_mosi = 0, in_frame = 0;
  logic [15:0] sh = '0;
  int rises = 0, viol = 0, last_rise = 0, last_mchg = 0, last_fall = 0;
  int cs_rise = 0, ldac_fall = 0, ldac_pulses = 0, frames = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1; prev_sclk = 0; prev_ldac = 1; prev_mosi = 0; in_frame = 0;
    end else begin
      if (prev_cs && !cs_n) begin
        in_frame = 1; sh = '0; rises = 0; viol = 0; last_mchg = cyc;
        check("busy_at_cs_fall", busy, 1);
      end else if (!cs_n && mosi !== prev_mosi) begin
        if (rises > 0 && cyc - last_rise < H) viol++;
        last_mchg = cyc;
      end
      if (!cs_n && sclk && !prev_sclk) begin
        if (cyc - last_mchg < H) viol++;
        sh = {sh[14:0], mosi};
        rises++;
        last_rise = cyc;
      end
      if (!cs_n && !sclk && prev_sclk) last_fall = cyc;
      if (!prev_cs && cs_n && in_frame) begin
        in_frame = 0;
        cs_rise = cyc;
        frames++;
        check("rises", rises, 16);
        check("cs_after_last_fall", cyc - last_fall, H);
        check("setup_hold", viol, 0);
        if (exp_q.size() == 0) check("frame_unexpected", sh, 16'hxxxx);
        else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("frame", sh, e);
          $display("[TB] frame %0d sent %04h expected %04h", frames, sh, e);
        end
      end
      if (prev_ldac && !ldac_n) begin
        check("ldac_delay", cyc - cs_rise, H);
        ldac_fall = cyc;
        ldac_pulses++;
      end
      if (!prev_ldac && ldac_n) begin
        check("ldac_width", cyc - ldac_fall, H);
        check("busy_at_ldac_rise", busy, 0);
      end
      prev_cs = cs_n; prev_sclk = sclk; prev_ldac = ldac_n; prev_mosi = mosi;
    end
  end

  // Monitor for the SCLK_DIV=1 instance fed with continuous 8'h55 strobes.
  logic        p1_cs = 1, p1_sclk = 0, in1 = 0, have_fall1 = 0;
  logic [15:0] sh1 = '0;
  int rises1 = 0, viol1 = 0, last_rise1 = 0, cs_fall1 = 0, frames1 = 0;

  always @(negedge clk) begin
    if (rst1_n) begin
      if (p1_cs && !cs1_n) begin
        if (have_fall1) check("fast_period", cyc - cs_fall1, FAST_CYC);
        have_fall1 = 1; cs_fall1 = cyc; in1 = 1; sh1 = '0; rises1 = 0; viol1 = 0;
      end
      if (!cs1_n && sclk1 && !p1_sclk) begin
        sh1 = {sh1[14:0], mosi1}; rises1++; last_rise1 = cyc;
      end
      if (!cs1_n && !sclk1 && p1_sclk && cyc - last_rise1 != 1) viol1++;
      if (!p1_cs && cs1_n && in1) begin
        in1 = 0; frames1++;
        check("fast_rises", rises1, 16);
        check("fast_sclk_half", viol1, 0);
        check("fast_frame", sh1, 16'h3550);
        $display("[TB] fast frame %0d sent %04h expected 3550", frames1, sh1);
      end
      p1_cs = cs1_n; p1_sclk = sclk1;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pending"}, pending, 0);
    check({tag, "_overrun"}, overrun_cnt, 0);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_sclk"}, sclk, 0);
    check({tag, "_mosi"}, mosi, 0);
    check({tag, "_ldac_n"}, ldac_n, 1);
  endtask

  initial begin
    int n;
    int pulses_before;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    rst1_n = 1'b1;
    sample_valid1 = 1'b1;
    idle_steps(3);

    // Single sample, then a buffered one.
    step(1'b1, 8'hA5); drain();
    step(1'b1, 8'h10); idle_steps(20); step(1'b1, 8'h20); drain();

    // Two strobes during one frame: the first buffered one is overwritten.
    step(1'b1, 8'h01); idle_steps(10); step(1'b1, 8'h02); idle_steps(10); step(1'b1, 8'h03);
    drain();
    check("overrun_one", overrun_cnt, 1);

    // Full buffer in IDLE with a simultaneous strobe.
    step(1'b1, 8'h11); idle_steps(15); step(1'b1, 8'h22);
    while (m_t + 1 < m_free) step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) step(($urandom_range(0, 19) == 0), 8'($urandom));
    drain();

    // Continuous strobes drive the overrun counter into saturation.
    for (int i = 0; i < 320; i++) step(1'b1, 8'($urandom));
    check("overrun_sat", overrun_cnt, 255);
    drain();

    // Reset during the 5th SCLK period.
    step(1'b1, 8'h77);
    n = 0;
    while (rises < 5 && n < 200) begin step(1'b0, 8'h00); n++; end
    check("rise5_timeout", n < 200, 1);
    pulses_before = ldac_pulses;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    m_pend = 0; m_over = 0; m_start = -1000; m_free = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_steps(40);
    check("no_ldac_after_abort", ldac_pulses, pulses_before);
    step(1'b1, 8'h00); drain();

    check("fast_frames_seen", frames1 > 5, 1);
    check("all_frames_sent", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
